frame_crc_to_fifo: RTL and testbench

Parametrised successor of the single-byte CRC-to-FIFO bridge. Accepts DATA_W-bit words from a transmitter over the armed tsent/trecieve two-phase handshake and feeds each word MSB-first through a serial CRC_W-bit LFSR. Each word is pushed into the downstream FIFO when the FIFO is not busy. After FRAME_LEN words it closes the frame, optionally appends the CRC word, pulses frame_done and re-initialises the CRC.

---
 rtl/frame_crc_pkg.sv | 23 ++
 rtl/crc_serial.sv | 33 +++
 rtl/frame_crc_to_fifo.sv | 179 +++++++++++++++++
 tb/tb_frame_crc_to_fifo.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_crc_pkg.sv
// Shared types and constants for the frame CRC to FIFO bridge.
// Optional CRC append is controlled by the FRAME_CRC_APPEND_EN macro.
package frame_crc_pkg;

  // Control states. CRCWR is only reachable when FRAME_CRC_APPEND_EN is defined.
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARMED = 3'd1,
    SHIFT = 3'd2,
    WRITE = 3'd3,
    CRCWR = 3'd4,
    DONE  = 3'd5
  } state_e;

  // Default CRC-8 generator (x^8 + x^2 + x + 1, top bit implicit) and seed
  localparam logic [7:0] CRC_POLY_DEF = 8'h07;
  localparam logic [7:0] CRC_INIT_DEF = 8'h00;

  // Sticky error flag positions
  localparam int ERR_PROTO = 0;
  localparam int ERR_BUSY  = 1;

endpackage

// File: rtl/crc_serial.sv
// Serial MSB-first LFSR CRC, one bit per enabled cycle.
// init has priority over en and reloads the seed.
module crc_serial
  import frame_crc_pkg::*;
#(
  parameter int               CRC_W    = 8,
  parameter logic [CRC_W-1:0] CRC_POLY = CRC_W'(CRC_POLY_DEF),
  parameter logic [CRC_W-1:0] CRC_INIT = CRC_W'(CRC_INIT_DEF)
)(
  input  logic             clk,
  input  logic             reset,
  input  logic             init,
  input  logic             en,
  input  logic             bit_in,
  output logic [CRC_W-1:0] crc
);

  logic fb;

  assign fb = bit_in ^ crc[CRC_W-1];

  // LFSR register: seed on reset/init, otherwise shift in one bit when enabled
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      crc <= CRC_INIT;
    end else if (init) begin
      crc <= CRC_INIT;
    end else if (en) begin
      crc <= (crc << 1) ^ (fb ? CRC_POLY : '0);
    end
  end

endmodule

// File: rtl/frame_crc_to_fifo.sv
// Word-wide CRC to FIFO bridge: accepts words over the tsent/trecieve
// handshake, folds each word serially into a running CRC, writes the word
// to the FIFO and closes a frame every FRAME_LEN words.
// Define FRAME_CRC_APPEND_EN to append the CRC as an extra FIFO write per frame.
module frame_crc_to_fifo
  import frame_crc_pkg::*;
#(
  parameter int               DATA_W       = 8,
  parameter int               CRC_W        = 8,
  parameter logic [CRC_W-1:0] CRC_POLY     = CRC_W'(CRC_POLY_DEF),
  parameter logic [CRC_W-1:0] CRC_INIT     = CRC_W'(CRC_INIT_DEF),
  parameter int               FRAME_LEN    = 4,
  parameter int               BUSY_TIMEOUT = 255,
  localparam int              CNT_W        = $clog2(FRAME_LEN+1)
)(
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [DATA_W-1:0] t_data,
  input  logic              tsent,
  output logic              trecieve,
  input  logic              fifo_busy,
  output logic              fifo_we,
  output logic [DATA_W-1:0] fifo_data,
  output logic [CRC_W-1:0]  crc,
  output logic              frame_done,
  output logic [CNT_W-1:0]  word_cnt,
  output logic [3:0]        error,
  input  logic              clr_err
);

  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int BCW   = (BUSY_TIMEOUT > 0) ? $clog2(BUSY_TIMEOUT+1) : 1;

  state_e            state, state_nx;
  logic [DATA_W-1:0] sreg;
  logic [BIT_W-1:0]  bit_cnt;
  logic [BCW-1:0]    busy_cnt;
  logic [CNT_W-1:0]  word_cnt_q;
  logic [DATA_W-1:0] fifo_data_q;
  logic              fifo_we_q;
  logic              trecieve_q;
  logic              tsent_q;
  logic [1:0]        err;
  logic [1:0]        err_set;
  logic              wr_word, wr_crc, busy_wait, last_word;
  logic              crc_en, crc_init;

  assign last_word = (word_cnt_q == CNT_W'(FRAME_LEN-1));

  // Next-state and per-cycle strobes; all state changes are gated by enable
  always_comb begin
    state_nx  = state;
    wr_word   = 1'b0;
    wr_crc    = 1'b0;
    busy_wait = 1'b0;
    case (state)
      IDLE:  if (!tsent) state_nx = ARMED;
      ARMED: if (tsent)  state_nx = SHIFT;
      SHIFT: if (bit_cnt == '0) state_nx = WRITE;
      WRITE: begin
        busy_wait = fifo_busy;
        if (!fifo_busy) begin
          wr_word = 1'b1;
          if (last_word) begin
`ifdef FRAME_CRC_APPEND_EN
            state_nx = CRCWR;
`else
            state_nx = DONE;
`endif
          end else begin
            state_nx = IDLE;
          end
        end
      end
`ifdef FRAME_CRC_APPEND_EN
      CRCWR: begin
        busy_wait = fifo_busy;
        if (!fifo_busy) begin
          wr_crc   = 1'b1;
          state_nx = DONE;
        end
      end
`endif
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Error sources: a falling tsent while a word is in flight, and a
  // saturated busy wait. The wait itself continues; nothing is dropped.
  always_comb begin
    err_set            = '0;
    err_set[ERR_PROTO] = enable && tsent_q && !tsent &&
                         (state == SHIFT || state == WRITE || state == CRCWR);
    err_set[ERR_BUSY]  = enable && busy_wait &&
                         (busy_cnt >= BCW'(BUSY_TIMEOUT-1));
  end

  assign crc_en   = enable && (state == SHIFT);
  assign crc_init = enable && (state == DONE);

  crc_serial #(
    .CRC_W    (CRC_W),
    .CRC_POLY (CRC_POLY),
    .CRC_INIT (CRC_INIT)
  ) u_crc (
    .clk    (clk),
    .reset  (reset),
    .init   (crc_init),
    .en     (crc_en),
    .bit_in (sreg[DATA_W-1]),
    .crc    (crc)
  );

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      state <= IDLE;
    else if (enable) state <= state_nx;
  end

  // Datapath: capture, shift, counters and the registered FIFO write.
  // A disabled cycle only clears the write strobe so a pulse is never repeated.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sreg        <= '0;
      bit_cnt     <= '0;
      busy_cnt    <= '0;
      word_cnt_q  <= '0;
      fifo_data_q <= '0;
      fifo_we_q   <= 1'b0;
      trecieve_q  <= 1'b0;
      tsent_q     <= 1'b0;
    end else if (!enable) begin
      fifo_we_q <= 1'b0;
    end else begin
      tsent_q    <= tsent;
      trecieve_q <= (state_nx == IDLE) || (state_nx == ARMED);
      fifo_we_q  <= wr_word | wr_crc;

      if (state == ARMED && tsent) begin
        sreg        <= t_data;
        fifo_data_q <= t_data;
        bit_cnt     <= BIT_W'(DATA_W-1);
      end

      if (state == SHIFT) begin
        sreg    <= sreg << 1;
        bit_cnt <= bit_cnt - 1'b1;
      end

      if (wr_word)          word_cnt_q <= word_cnt_q + 1'b1;
      else if (state == DONE) word_cnt_q <= '0;

      if (wr_crc) fifo_data_q <= DATA_W'(crc);

      if (busy_wait) begin
        if (busy_cnt != BCW'(BUSY_TIMEOUT)) busy_cnt <= busy_cnt + 1'b1;
      end else begin
        busy_cnt <= '0;
      end
    end
  end

  // Sticky error flags; clear wins over a same-cycle set
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       err <= '0;
    else if (clr_err) err <= '0;
    else              err <= err | err_set;
  end

  assign trecieve   = trecieve_q;
  assign fifo_we    = fifo_we_q & enable;
  assign fifo_data  = fifo_data_q;
  assign frame_done = enable && (state == DONE);
  assign word_cnt   = word_cnt_q;
  assign error      = {2'b00, err};

endmodule

// File: tb/tb_frame_crc_to_fifo.sv
// Directed bench for frame_crc_to_fifo: one instance with FRAME_LEN=1 and one
// with FRAME_LEN=9. Expectations follow FRAME_CRC_APPEND_EN when defined.
module tb_frame_crc_to_fifo;

`ifdef FRAME_CRC_APPEND_EN
  localparam int APP = 1;
`else
  localparam int APP = 0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       enable = 1'b1;
  logic       fifo_busy = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] t_data = 8'h00;
  logic       tsent1 = 1'b1;
  logic       tsent9 = 1'b1;

  logic       trecieve1, fifo_we1, frame_done1;
  logic [7:0] fifo_data1, crc1;
  logic [0:0] word_cnt1;
  logic [3:0] error1;

  logic       trecieve9, fifo_we9, frame_done9;
  logic [7:0] fifo_data9, crc9;
  logic [3:0] word_cnt9;
  logic [3:0] error9;

  int checks = 0;
  int errors = 0;

  logic [7:0] q1[$];
  logic [7:0] q9[$];
  int         fd1 = 0, fd9 = 0;
  logic [7:0] fdcrc1 = 8'h00, fdcrc9 = 8'h00;

  frame_crc_to_fifo #(.DATA_W(8), .CRC_W(8), .CRC_POLY(8'h07), .CRC_INIT(8'h00),
                      .FRAME_LEN(1), .BUSY_TIMEOUT(255)) u_dut1 (
    .clk(clk), .reset(reset), .enable(enable), .t_data(t_data), .tsent(tsent1),
    .trecieve(trecieve1), .fifo_busy(fifo_busy), .fifo_we(fifo_we1),
    .fifo_data(fifo_data1), .crc(crc1), .frame_done(frame_done1),
    .word_cnt(word_cnt1), .error(error1), .clr_err(clr_err)
  );

  frame_crc_to_fifo #(.DATA_W(8), .CRC_W(8), .CRC_POLY(8'h07), .CRC_INIT(8'h00),
                      .FRAME_LEN(9), .BUSY_TIMEOUT(255)) u_dut9 (
    .clk(clk), .reset(reset), .enable(enable), .t_data(t_data), .tsent(tsent9),
    .trecieve(trecieve9), .fifo_busy(fifo_busy), .fifo_we(fifo_we9),
    .fifo_data(fifo_data9), .crc(crc9), .frame_done(frame_done9),
    .word_cnt(word_cnt9), .error(error9), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  // Log FIFO writes and frame completions shortly after each rising edge
  always @(posedge clk) begin
    #2;
    if (fifo_we1) q1.push_back(fifo_data1);
    if (fifo_we9) q9.push_back(fifo_data9);
    if (frame_done1) begin fd1++; fdcrc1 = crc1; end
    if (frame_done9) begin fd9++; fdcrc9 = crc9; end
  end

  // Wait for ready, arm with tsent low, present the word; returns on the
  // falling edge right after the capture edge.
  task automatic arm(input bit s9, input logic [7:0] d);
    int n;
    n = 0;
    while ((s9 ? trecieve9 : trecieve1) !== 1'b1 && n < 100) begin
      @(negedge clk); n++;
    end
    checks++;
    if (n >= 100) begin
      errors++; $display("FAIL arm_ready: trecieve=%b after %0d cycles, required 1", s9 ? trecieve9 : trecieve1, n);
    end
    if (s9) tsent9 = 1'b0; else tsent1 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    t_data = d;
    if (s9) tsent9 = 1'b1; else tsent1 = 1'b1;
    @(negedge clk);
  endtask

  // Count falling edges until fifo_we, starting from k0
  task automatic wait_we(input bit s9, input int k0, output int k);
    k = k0;
    while ((s9 ? fifo_we9 : fifo_we1) !== 1'b1 && k < 600) begin
      @(negedge clk); k++;
    end
    checks++;
    if (k >= 600) begin
      errors++; $display("FAIL wait_we: no fifo_we within %0d cycles, required a write", k);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({trecieve1, fifo_we1, fifo_data1, crc1, frame_done1, word_cnt1, error1} !== 24'd0) begin
      errors++; $display("FAIL reset_dut1: outputs=%h required 0",
        {trecieve1, fifo_we1, fifo_data1, crc1, frame_done1, word_cnt1, error1});
    end
    checks++;
    if ({trecieve9, fifo_we9, fifo_data9, crc9, frame_done9, word_cnt9, error9} !== 27'd0) begin
      errors++; $display("FAIL reset_dut9: outputs=%h required 0",
        {trecieve9, fifo_we9, fifo_data9, crc9, frame_done9, word_cnt9, error9});
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (trecieve9 !== 1'b1) begin
      errors++; $display("FAIL idle_ready: trecieve=%b required 1", trecieve9);
    end
  endtask

  task automatic test_single();
    int k;
    q1.delete();
    arm(1'b0, 8'h01);
    wait_we(1'b0, 0, k);
    checks++;
    if (k !== 9) begin errors++; $display("FAIL single_latency: %0d cycles required 9", k); end
    repeat (10) @(negedge clk);
    checks++;
    if (q1.size() !== 1 + APP) begin
      errors++; $display("FAIL single_count: %0d writes required %0d", q1.size(), 1 + APP);
    end else begin
      checks++;
      if (q1[0] !== 8'h01) begin errors++; $display("FAIL single_word: %h required 01", q1[0]); end
`ifdef FRAME_CRC_APPEND_EN
      checks++;
      if (q1[1] !== 8'h07) begin errors++; $display("FAIL single_crcword: %h required 07", q1[1]); end
`endif
    end
    checks++;
    if (fd1 !== 1) begin errors++; $display("FAIL single_done: %0d pulses required 1", fd1); end
    checks++;
    if (fdcrc1 !== 8'h07) begin errors++; $display("FAIL single_crc: %h required 07", fdcrc1); end
    checks++;
    if ({crc1, word_cnt1} !== 9'd0) begin
      errors++; $display("FAIL single_reinit: crc=%h cnt=%0d required 00/0", crc1, word_cnt1);
    end
  endtask

  // "123456789" frame; word 5 also carries a 5-cycle enable gap mid-shift
  task automatic test_check_string();
    int k, k0;
    logic [7:0] c;
    q9.delete();
    fd9 = 0;
    for (int i = 0; i < 9; i++) begin
      arm(1'b1, 8'h31 + 8'(i));
      k0 = 0;
      if (i == 4) begin
        repeat (2) begin @(negedge clk); k0++; end
        enable = 1'b0;
        c = crc9;
        repeat (5) begin @(negedge clk); k0++; end
        checks++;
        if (crc9 !== c) begin errors++; $display("FAIL enable_hold_crc: %h required %h", crc9, c); end
        enable = 1'b1;
      end
      wait_we(1'b1, k0, k);
      checks++;
      if (k !== ((i == 4) ? 14 : 9)) begin
        errors++; $display("FAIL string_latency word %0d: %0d cycles required %0d", i, k, (i == 4) ? 14 : 9);
      end
      if (i == 0) begin
        checks++;
        if (word_cnt9 !== 4'd1) begin errors++; $display("FAIL string_wordcnt: %0d required 1", word_cnt9); end
      end
    end
    repeat (10) @(negedge clk);
    checks++;
    if (fdcrc9 !== 8'hF4) begin errors++; $display("FAIL string_crc: %h required F4", fdcrc9); end
    checks++;
    if (fd9 !== 1) begin errors++; $display("FAIL string_done: %0d pulses required 1", fd9); end
    checks++;
    if (q9.size() !== 9 + APP) begin
      errors++; $display("FAIL string_count: %0d writes required %0d", q9.size(), 9 + APP);
    end else begin
      checks++;
      if (q9[8] !== 8'h39) begin errors++; $display("FAIL string_last: %h required 39", q9[8]); end
`ifdef FRAME_CRC_APPEND_EN
      checks++;
      if (q9[9] !== 8'hF4) begin errors++; $display("FAIL string_crcword: %h required F4", q9[9]); end
`endif
    end
  endtask

  task automatic test_busy_timeout();
    int n0;
    n0 = q9.size();
    fifo_busy = 1'b1;
    arm(1'b1, 8'hA5);
    repeat (200) @(negedge clk);
    checks++;
    if (error9 !== 4'b0000) begin errors++; $display("FAIL busy_early: error=%b required 0000", error9); end
    repeat (100) @(negedge clk);
    checks++;
    if (error9 !== 4'b0010) begin errors++; $display("FAIL busy_timeout: error=%b required 0010", error9); end
    checks++;
    if (q9.size() !== n0) begin errors++; $display("FAIL busy_nowrite: %0d writes required %0d", q9.size(), n0); end
    fifo_busy = 1'b0;
    @(negedge clk);
    checks++;
    if ({fifo_we9, fifo_data9} !== 9'h1A5) begin
      errors++; $display("FAIL busy_release: we=%b data=%h required 1/A5", fifo_we9, fifo_data9);
    end
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    checks++;
    if (error9 !== 4'b0000) begin errors++; $display("FAIL busy_clear: error=%b required 0000", error9); end
  endtask

  task automatic test_protocol_err();
    int k, n0;
    n0 = q9.size();
    arm(1'b1, 8'h5A);
    repeat (3) @(negedge clk);
    tsent9 = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (error9 !== 4'b0001) begin errors++; $display("FAIL proto_flag: error=%b required 0001", error9); end
    wait_we(1'b1, 5, k);
    checks++;
    if (k !== 9 || fifo_data9 !== 8'h5A) begin
      errors++; $display("FAIL proto_complete: latency=%0d data=%h required 9/5A", k, fifo_data9);
    end
    repeat (30) @(negedge clk);
    checks++;
    if (q9.size() !== n0 + 1 || word_cnt9 !== 4'd2) begin
      errors++; $display("FAIL proto_noextra: writes=%0d cnt=%0d required %0d/2", q9.size() - n0, word_cnt9, 1);
    end
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
  endtask

  task automatic test_reset_mid();
    int k;
    arm(1'b1, 8'hC3);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({trecieve9, fifo_we9, fifo_data9, crc9, frame_done9, word_cnt9, error9} !== 27'd0) begin
      errors++; $display("FAIL reset_mid: outputs=%h required 0",
        {trecieve9, fifo_we9, fifo_data9, crc9, frame_done9, word_cnt9, error9});
    end
    reset = 1'b1;
    repeat (2) @(negedge clk);
    arm(1'b1, 8'h00);
    wait_we(1'b1, 0, k);
    checks++;
    if ({crc9, word_cnt9} !== 12'h001) begin
      errors++; $display("FAIL reset_zero_word: crc=%h cnt=%0d required 00/1", crc9, word_cnt9);
    end
    arm(1'b1, 8'h31);
    wait_we(1'b1, 0, k);
    checks++;
    if (crc9 !== 8'h97) begin errors++; $display("FAIL reset_next_crc: %h required 97", crc9); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_check_string();
    test_busy_timeout();
    test_protocol_err();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $fatal(1);
  end

endmodule
